// File: rtl/pipeline_hazard_ctrl.sv
// In-order issue controller between decode/register-read and execute.
// Tracks outstanding register writes and holds issue on RAW/WAW hazards.
// Serialises the multi-cycle MUL/DIV unit and waits for branch-class resolution.
module pipeline_hazard_ctrl #(
  parameter int unsigned OPCODE_WIDTH    = 4,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned INSTR_WIDTH     = 30,
  parameter int unsigned MDU_LAT         = 4,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                         clk_in,
  input  logic                         RST,
  input  logic                         dec_valid,
  input  logic [INSTR_WIDTH-1:0]       dec_instr,
  input  logic                         wb_en,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_addr,
  input  logic                         br_resolve,
  input  logic                         br_taken,
  output logic                         issue,
  output logic                         stall,
  output logic                         flush,
  output logic                         mdu_start,
  output logic                         mdu_busy,
  output logic [2**REG_ADDR_WIDTH-1:0] pending,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
);

  localparam int unsigned NumRegs  = 2**REG_ADDR_WIDTH;
  localparam int unsigned CntWidth = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CntWidth-1:0] CntInit = CntWidth'(MDU_LAT - 1);

  // Shared processor opcode map.
  localparam logic [OPCODE_WIDTH-1:0] OpNop  = 'd0;
  localparam logic [OPCODE_WIDTH-1:0] OpLw   = 'd1;
  localparam logic [OPCODE_WIDTH-1:0] OpSw   = 'd2;
  localparam logic [OPCODE_WIDTH-1:0] OpAdd  = 'd3;
  localparam logic [OPCODE_WIDTH-1:0] OpSub  = 'd4;
  localparam logic [OPCODE_WIDTH-1:0] OpMul  = 'd5;
  localparam logic [OPCODE_WIDTH-1:0] OpDiv  = 'd6;
  localparam logic [OPCODE_WIDTH-1:0] OpAnd  = 'd7;
  localparam logic [OPCODE_WIDTH-1:0] OpOr   = 'd8;
  localparam logic [OPCODE_WIDTH-1:0] OpNot  = 'd9;
  localparam logic [OPCODE_WIDTH-1:0] OpCmp  = 'd10;
  localparam logic [OPCODE_WIDTH-1:0] OpJr   = 'd11;
  localparam logic [OPCODE_WIDTH-1:0] OpJpc  = 'd12;
  localparam logic [OPCODE_WIDTH-1:0] OpBrfl = 'd13;
  localparam logic [OPCODE_WIDTH-1:0] OpCall = 'd14;
  localparam logic [OPCODE_WIDTH-1:0] OpRet  = 'd15;

  typedef enum logic [1:0] {StRun, StMduWait, StBrWait} state_e;

  state_e                     state_q;
  logic [CntWidth-1:0]        mdu_cnt_q;
  logic                       mdu_busy_q;
  logic                       flush_q;
  logic [NumRegs-1:0]         pending_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

  logic [OPCODE_WIDTH-1:0]    opcode;
  logic [REG_ADDR_WIDTH-1:0]  reg_1;
  logic [REG_ADDR_WIDTH-1:0]  reg_2;
  logic                       uses_r1;
  logic                       uses_r2;
  logic                       has_dest;
  logic                       is_mdu;
  logic                       is_branch;
  logic [NumRegs-1:0]         wb_mask;
  logic [NumRegs-1:0]         dest_mask;
  logic [NumRegs-1:0]         pend_eff;
  logic                       hazard;
  logic                       unused_imm;

  assign opcode = dec_instr[OPCODE_WIDTH-1:0];
  assign reg_1  = dec_instr[OPCODE_WIDTH +: REG_ADDR_WIDTH];
  assign reg_2  = dec_instr[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  // Immediate field is carried by the instruction but never inspected here.
  assign unused_imm = ^dec_instr[INSTR_WIDTH-1:OPCODE_WIDTH+2*REG_ADDR_WIDTH];

  // Classify the decoding instruction: which fields it reads and writes.
  always_comb begin
    uses_r1   = 1'b0;
    uses_r2   = 1'b0;
    has_dest  = 1'b0;
    is_mdu    = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OpLw: begin
        has_dest = 1'b1;
        uses_r2  = 1'b1;
      end
      OpSw, OpCmp: begin
        uses_r1 = 1'b1;
        uses_r2 = 1'b1;
      end
      OpAdd, OpSub, OpAnd, OpOr: begin
        has_dest = 1'b1;
        uses_r1  = 1'b1;
        uses_r2  = 1'b1;
      end
      OpMul, OpDiv: begin
        has_dest = 1'b1;
        uses_r1  = 1'b1;
        uses_r2  = 1'b1;
        is_mdu   = 1'b1;
      end
      OpNot: begin
        has_dest = 1'b1;
        uses_r2  = 1'b1;
      end
      OpJr: begin
        uses_r1   = 1'b1;
        is_branch = 1'b1;
      end
      OpJpc, OpBrfl, OpCall, OpRet: begin
        is_branch = 1'b1;
      end
      OpNop:   ;
      default: ;
    endcase
  end

  // One-hot masks for this cycle's writeback and for the issuing destination.
  always_comb begin
    wb_mask   = '0;
    dest_mask = '0;
    if (wb_en) wb_mask[wb_addr] = 1'b1;
    if (issue && has_dest) dest_mask[reg_1] = 1'b1;
  end

  // Same-cycle writeback satisfies a hazard because the regfile is write-first.
  assign pend_eff = pending_q & ~wb_mask;
  assign hazard   = (uses_r1 & pend_eff[reg_1]) | (uses_r2 & pend_eff[reg_2]) |
                    (has_dest & pend_eff[reg_1]);

  assign issue     = (state_q == StRun) & dec_valid & ~hazard;
  assign stall     = dec_valid & ~issue;
  assign mdu_start = issue & is_mdu;

  assign flush     = flush_q;
  assign mdu_busy  = mdu_busy_q;
  assign pending   = pending_q;
  assign stall_cnt = stall_cnt_q;

  // Issue FSM: MDU occupancy countdown and branch-resolve hold.
  always_ff @(posedge clk_in) begin
    if (!RST) begin
      state_q    <= StRun;
      mdu_cnt_q  <= '0;
      mdu_busy_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (mdu_start) begin
            state_q    <= StMduWait;
            mdu_cnt_q  <= CntInit;
            mdu_busy_q <= 1'b1;
          end else if (issue && is_branch) begin
            state_q <= StBrWait;
          end
        end
        StMduWait: begin
          if (mdu_cnt_q == '0) begin
            state_q    <= StRun;
            mdu_busy_q <= 1'b0;
          end else begin
            mdu_cnt_q <= mdu_cnt_q - 1'b1;
          end
        end
        StBrWait: begin
          if (br_resolve) begin
            state_q <= StRun;
            flush_q <= br_taken;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Scoreboard: writeback clears, issuing destination sets (set wins).
  always_ff @(posedge clk_in) begin
    if (!RST) begin
      pending_q <= '0;
    end else begin
      pending_q <= pend_eff | dest_mask;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_in) begin
    if (!RST) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MduLat = 4;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpLw   = 4'd1;
  localparam logic [3:0] OpSw   = 4'd2;
  localparam logic [3:0] OpAdd  = 4'd3;
  localparam logic [3:0] OpSub  = 4'd4;
  localparam logic [3:0] OpMul  = 4'd5;
  localparam logic [3:0] OpDiv  = 4'd6;
  localparam logic [3:0] OpAnd  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpNot  = 4'd9;
  localparam logic [3:0] OpCmp  = 4'd10;
  localparam logic [3:0] OpJr   = 4'd11;
  localparam logic [3:0] OpJpc  = 4'd12;
  localparam logic [3:0] OpBrfl = 4'd13;
  localparam logic [3:0] OpCall = 4'd14;
  localparam logic [3:0] OpRet  = 4'd15;

  logic        clk_in = 1'b0;
  logic        RST;
  logic        dec_valid;
  logic [29:0] dec_instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        br_resolve;
  logic        br_taken;

  logic        issue, stall, flush, mdu_start, mdu_busy;
  logic [31:0] pending;
  logic [15:0] stall_cnt;
  logic        issue_w4, stall_w4, flush_w4, mdu_start_w4, mdu_busy_w4;
  logic [31:0] pending_w4;
  logic [3:0]  stall_cnt_w4;

  always #5 clk_in = ~clk_in;

  pipeline_hazard_ctrl #(
    .MDU_LAT(MduLat)
  ) dut (
    .clk_in    (clk_in),
    .RST       (RST),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .br_resolve(br_resolve),
    .br_taken  (br_taken),
    .issue     (issue),
    .stall     (stall),
    .flush     (flush),
    .mdu_start (mdu_start),
    .mdu_busy  (mdu_busy),
    .pending   (pending),
    .stall_cnt (stall_cnt)
  );

  // Narrow-counter instance to reach saturation quickly.
  pipeline_hazard_ctrl #(
    .MDU_LAT        (MduLat),
    .STALL_CNT_WIDTH(4)
  ) dut_w4 (
    .clk_in    (clk_in),
    .RST       (RST),
    .dec_valid (dec_valid),
    .dec_instr (dec_instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .br_resolve(br_resolve),
    .br_taken  (br_taken),
    .issue     (issue_w4),
    .stall     (stall_w4),
    .flush     (flush_w4),
    .mdu_start (mdu_start_w4),
    .mdu_busy  (mdu_busy_w4),
    .pending   (pending_w4),
    .stall_cnt (stall_cnt_w4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit [31:0] m_pend;
  int        m_mdu_left;
  bit        m_br;
  bit        m_flush;
  int        m_sc16;
  int        m_sc4;

  function automatic bit op_writes(input logic [3:0] op);
    return op inside {OpLw, OpAdd, OpSub, OpMul, OpDiv, OpAnd, OpOr, OpNot};
  endfunction
  function automatic bit op_reads1(input logic [3:0] op);
    return op inside {OpAdd, OpSub, OpMul, OpDiv, OpAnd, OpOr, OpCmp, OpSw, OpJr};
  endfunction
  function automatic bit op_reads2(input logic [3:0] op);
    return op inside {OpAdd, OpSub, OpMul, OpDiv, OpAnd, OpOr, OpCmp, OpSw, OpNot, OpLw};
  endfunction
  function automatic bit op_mdu(input logic [3:0] op);
    return op inside {OpMul, OpDiv};
  endfunction
  function automatic bit op_branch(input logic [3:0] op);
    return op inside {OpJr, OpJpc, OpBrfl, OpCall, OpRet};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend     = '0;
    m_mdu_left = 0;
    m_br       = 1'b0;
    m_flush    = 1'b0;
    m_sc16     = 0;
    m_sc4      = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model across the
  // rising edge using the inputs that were applied for this cycle.
  task automatic do_cycle();
    logic [3:0] op;
    int         r1, r2;
    bit [31:0]  eff;
    bit         haz, e_issue, e_stall, e_start, nflush;
    @(negedge clk_in);
    op  = dec_instr[3:0];
    r1  = int'(dec_instr[8:4]);
    r2  = int'(dec_instr[13:9]);
    eff = m_pend;
    if (wb_en) eff[wb_addr] = 1'b0;
    haz = (op_reads1(op) && eff[r1]) || (op_reads2(op) && eff[r2]) ||
          (op_writes(op) && eff[r1]);
    e_issue = dec_valid && !m_br && (m_mdu_left == 0) && !haz;
    e_stall = dec_valid && !e_issue;
    e_start = e_issue && op_mdu(op);

    check("issue",        32'(issue),        32'(e_issue));
    check("stall",        32'(stall),        32'(e_stall));
    check("mdu_start",    32'(mdu_start),    32'(e_start));
    check("flush",        32'(flush),        32'(m_flush));
    check("mdu_busy",     32'(mdu_busy),     32'(m_mdu_left > 0));
    check("pending",      pending,           m_pend);
    check("stall_cnt",    32'(stall_cnt),    32'(m_sc16));
    check("w4_issue",     32'(issue_w4),     32'(e_issue));
    check("w4_stall",     32'(stall_w4),     32'(e_stall));
    check("w4_mdu_start", 32'(mdu_start_w4), 32'(e_start));
    check("w4_flush",     32'(flush_w4),     32'(m_flush));
    check("w4_mdu_busy",  32'(mdu_busy_w4),  32'(m_mdu_left > 0));
    check("w4_pending",   pending_w4,        m_pend);
    check("w4_stall_cnt", 32'(stall_cnt_w4), 32'(m_sc4));

    if (!RST) begin
      model_reset();
    end else begin
      nflush = 1'b0;
      if (m_br && br_resolve) begin
        m_br   = 1'b0;
        nflush = br_taken;
      end
      if (m_mdu_left > 0) m_mdu_left--;
      m_pend = eff;
      if (e_issue && op_writes(op)) m_pend[r1] = 1'b1;
      if (e_issue && op_mdu(op))    m_mdu_left = MduLat;
      if (e_issue && op_branch(op)) m_br = 1'b1;
      if (e_stall) begin
        if (m_sc16 < 65535) m_sc16++;
        if (m_sc4 < 15)     m_sc4++;
      end
      m_flush = nflush;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic step(input bit v, input logic [3:0] op, input int r1, input int r2,
                      input bit we, input int wa, input bit brr, input bit brt);
    dec_valid  = v;
    dec_instr  = {16'($urandom), 5'(r2), 5'(r1), op};
    wb_en      = we;
    wb_addr    = 5'(wa);
    br_resolve = brr;
    br_taken   = brt;
    do_cycle();
  endtask

  initial begin
    RST        = 1'b0;
    dec_valid  = 1'b0;
    dec_instr  = '0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    @(posedge clk_in);
    #1;
    model_reset();

    // Reset state.
    step(0, OpNop, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;

    // ADD R3,R17 issues immediately.
    step(1, OpAdd, 3, 17, 0, 0, 0, 0);
    check("plan_add_pend", pending, 32'h0000_0008);

    // SUB R5,R3 waits for R3 writeback.
    for (int i = 0; i < 3; i++) step(1, OpSub, 5, 3, 0, 0, 0, 0);
    check("plan_raw_stall_cnt", 32'(stall_cnt), 32'd3);
    step(1, OpSub, 5, 3, 1, 3, 0, 0);
    check("plan_raw_pend", pending, 32'h0000_0020);
    step(0, OpNop, 0, 0, 1, 5, 0, 0);

    // MUL R2,R3 then NOP held for the MDU occupancy.
    step(1, OpMul, 2, 3, 0, 0, 0, 0);
    check("plan_mdu_busy", 32'(mdu_busy), 32'd1);
    for (int i = 0; i < 5; i++) step(1, OpNop, 0, 0, 0, 0, 0, 0);
    step(0, OpNop, 0, 0, 1, 2, 0, 0);

    // br_resolve while in RUN is ignored.
    step(0, OpNop, 0, 0, 0, 0, 1, 1);

    // BRFL taken, then not taken.
    for (int t = 1; t >= 0; t--) begin
      step(1, OpBrfl, 0, 0, 0, 0, 0, 0);
      step(1, OpNop, 0, 0, 0, 0, 0, 0);
      step(1, OpNop, 0, 0, 0, 0, 0, 0);
      step(1, OpNop, 0, 0, 0, 0, 1, 1'(t));
      check("plan_br_flush", 32'(flush), 32'(t));
      step(1, OpNop, 0, 0, 0, 0, 0, 0);
    end

    // Set wins over same-cycle clear.
    step(1, OpLw, 7, 0, 0, 0, 0, 0);
    step(1, OpLw, 7, 0, 1, 7, 0, 0);
    check("plan_set_wins", pending, 32'h0000_0080);
    step(0, OpNop, 0, 0, 1, 7, 0, 0);

    // Reset in the middle of an MDU operation.
    step(1, OpLw, 3, 0, 0, 0, 0, 0);
    step(1, OpMul, 2, 0, 0, 0, 0, 0);
    check("plan_mid_pend", pending, 32'h0000_000C);
    step(1, OpNop, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    step(1, OpNop, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    check("plan_rst_pend", pending, 32'h0);
    check("plan_rst_busy", 32'(mdu_busy), 32'd0);
    check("plan_rst_flush", 32'(flush), 32'd0);
    check("plan_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Long stall saturates the narrow counter.
    step(1, OpLw, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, OpAdd, 4, 1, 0, 0, 0, 0);
    check("plan_sat_w4", 32'(stall_cnt_w4), 32'd15);
    check("plan_sat_w16", 32'(stall_cnt), 32'd20);
    step(1, OpAdd, 4, 1, 1, 1, 0, 0);
    step(0, OpNop, 0, 0, 1, 4, 0, 0);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(63) != 0);
      step(($urandom_range(3) != 0), 4'($urandom_range(15)),
           int'($urandom_range(7)), int'($urandom_range(7)),
           1'($urandom_range(1)),
           ($urandom_range(7) == 0) ? int'($urandom_range(31)) : int'($urandom_range(7)),
           ($urandom_range(3) == 0), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- In-order issue controller between the decode/register-read stage and execute.
- Keeps a per-register pending-write scoreboard and detects RAW hazards on the decoding instruction.
- Serialises the multi-cycle MUL/DIV unit and holds issue until branch-class instructions resolve.
- Drives stall/issue to the decode stage and flush to fetch/decode; opcode encodings come from the shared processor parameter include.

Parameters:
OPCODE_WIDTH, 4, opcode field width
REG_ADDR_WIDTH, 5, register address width (32 registers)
INSTR_WIDTH, 30, instruction width: opcode[3:0], REG_1[8:4], REG_2[13:9], imm[29:14]
MDU_LAT, 4, MUL/DIV occupancy in cycles (>=1)
STALL_CNT_WIDTH, 16, stall performance counter width

Ports:
clk_in  in  1  clock, all state on rising edge
RST  in  1  synchronous active-low reset
dec_valid  in  1  decode stage holds a valid instruction
dec_instr  in  INSTR_WIDTH  instruction in decode
wb_en  in  1  register-file write this cycle
wb_addr  in  REG_ADDR_WIDTH  register being written
br_resolve  in  1  execute resolved outstanding branch-class instruction
br_taken  in  1  qualifies br_resolve: redirect taken
issue  out  1  decode instruction advances this cycle (combinational)
stall  out  1  dec_valid && !issue (combinational)
flush  out  1  one-cycle registered pulse, discard fetch/decode contents
mdu_start  out  1  MUL/DIV issued this cycle (combinational, subset of issue)
mdu_busy  out  1  registered, high while state = MDU_WAIT
pending  out  2**REG_ADDR_WIDTH  registered scoreboard, bit n = write to Rn outstanding
stall_cnt  out  STALL_CNT_WIDTH  cycles with stall=1, saturating

Behaviour:
- Reset (RST=0 at clock edge): state RUN, pending=0, flush=0, mdu_busy=0, MDU counter=0, stall_cnt=0. Applies mid-MDU or mid-branch: outstanding op forgotten, no flush generated.
- Destination (REG_1): LW, ADD, SUB, MUL, DIV, AND, OR, NOT. No destination: SW, CMP, JR, JPC, BRFL, CALL, RET, NOP.
- Sources: ADD/SUB/MUL/DIV/AND/OR/CMP/SW read REG_1 and REG_2; NOT and LW read REG_2; JR reads REG_1; others none.
- Effective pending: pending & ~(wb_en ? onehot(wb_addr) : 0). Same-cycle writeback satisfies the hazard; regfile is write-first.
- Hazard: any used source has effective pending bit set. A destination-only pending bit is also a hazard (WAW).
- State RUN: issue = dec_valid && !hazard.
  - Issued MUL/DIV: mdu_start=1, counter <= MDU_LAT-1, next state MDU_WAIT.
  - Issued JR/JPC/BRFL/CALL/RET: next state BR_WAIT.
  - Otherwise stay in RUN.
- State MDU_WAIT: issue=0. If counter==0, next state RUN; else decrement.
- State MDU_WAIT duration: exactly MDU_LAT cycles.
- State BR_WAIT: issue=0. On br_resolve, next state RUN and flush <= br_taken. Issue resumes the cycle after resolve.
- br_resolve outside BR_WAIT: ignored.
- Scoreboard update each edge:
  - Clear bit wb_addr if wb_en.
  - Set bit dest on issue with destination.
  - Set and clear on the same address in the same cycle: set wins.
  - wb_en to a non-pending register: harmless, bit remains 0.
- Register 0 is tracked like any other register.
- Latency: a hazard-free instruction in RUN issues in the same cycle it is presented. A dependent instruction issues in the cycle its producer's wb_en appears.
- stall_cnt: +1 on every edge with stall=1, holds at all-ones.

Test Plan:
- Reset then dec_valid ADD R3,R17 with pending=0 -> issue=1, stall=0, next cycle pending=0x00000008.
- ADD R3 issued, then SUB R5,R3 presented, wb_en=0 for 3 cycles -> stall=1 for 3 cycles, stall_cnt=3. On wb_en=1 wb_addr=3: SUB issues that cycle; next pending bit3=0, bit5=1.
- MUL R2,R3 issued with MDU_LAT=4 -> mdu_start pulse, mdu_busy=1 for 4 cycles, following NOP stalled 4 cycles, issues 5th cycle after MUL.
- BRFL issued, br_resolve=1 br_taken=1 after 2 cycles -> stall 3 cycles incl. resolve cycle, flush=1 one cycle after resolve, then issue resumes. Repeat with br_taken=0 -> flush stays 0.
- Same cycle: LW R7 issues while wb_en=1 wb_addr=7 (older pending) -> pending bit7 remains 1 (set wins).
- RST=0 during MDU_WAIT with pending=0x0000000C -> next cycle pending=0, mdu_busy=0, flush=0, stall_cnt=0, state RUN; stall_cnt saturation checked with width forced to 4 -> holds at 15.
